text_stream_writer: RTL and testbench

- Producer side of the video memory external write port (`write`, `xtextwrite`, `ytextwrite`, `value`).
- Accepts a byte stream over a valid/ready handshake and interprets control codes.
- Keeps a text cursor and issues one write-strobe sequence per printable character.
- Supports a full-screen clear. Sits between the host/UART command path and video memory.

---
 rtl/text_stream_writer.sv | 188 ++++++++++++++++++
 tb/tb_text_stream_writer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_stream_writer.sv
// Turns a byte stream into text cells on the video memory write port. It keeps a cursor,
// handles CR/LF/BS/FF and clears the screen. Define TEXT_STREAM_WRITER_TAB_EN to make 0x09 a tab.
module text_stream_writer #(
    parameter int unsigned TEXT_COLS = 100,
    parameter int unsigned TEXT_ROWS = 37,
    parameter int unsigned X_W       = 7,
    parameter int unsigned Y_W       = 6,
    parameter int unsigned ATTR_W    = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                attr_load,
    input  logic [ATTR_W-1:0]   attr_in,
    output logic                busy,
    output logic [X_W-1:0]      cursor_x,
    output logic [Y_W-1:0]      cursor_y,
    output logic                write,
    output logic [X_W-1:0]      xtextwrite,
    output logic [Y_W-1:0]      ytextwrite,
    output logic [ATTR_W+7:0]   value
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_CLR_SETUP, S_CLR_STROBE
    } state_t;

    localparam logic [X_W-1:0] X_LAST = X_W'(TEXT_COLS - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(TEXT_ROWS - 1);
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
`ifdef TEXT_STREAM_WRITER_TAB_EN
    localparam logic [7:0] CH_HT    = 8'h09;
`endif

    state_t               state_q, state_d;
    logic                 write_q, write_d;
    logic                 in_ready_q, in_ready_d;
    logic                 busy_q, busy_d;
    logic [X_W-1:0]       cursor_x_q, cursor_x_d;
    logic [Y_W-1:0]       cursor_y_q, cursor_y_d;
    logic [X_W-1:0]       xtextwrite_q, xtextwrite_d;
    logic [Y_W-1:0]       ytextwrite_q, ytextwrite_d;
    logic [ATTR_W+7:0]    value_q, value_d;
    logic [ATTR_W-1:0]    attr_q, attr_d;

    logic [X_W-1:0]       adv_x_c, clr_x_c;
    logic [Y_W-1:0]       adv_y_c, clr_y_c, lf_y_c;
    logic                 clr_last_c;

    // Row-major successor of the cursor and of the clear address (wraps to the top, no scroll)
    assign lf_y_c     = (cursor_y_q == Y_LAST) ? '0 : cursor_y_q + Y_W'(1);
    assign adv_x_c    = (cursor_x_q == X_LAST) ? '0 : cursor_x_q + X_W'(1);
    assign adv_y_c    = (cursor_x_q == X_LAST) ? lf_y_c : cursor_y_q;
    assign clr_x_c    = (xtextwrite_q == X_LAST) ? '0 : xtextwrite_q + X_W'(1);
    assign clr_y_c    = (xtextwrite_q == X_LAST) ? ytextwrite_q + Y_W'(1) : ytextwrite_q;
    assign clr_last_c = (xtextwrite_q == X_LAST) && (ytextwrite_q == Y_LAST);

`ifdef TEXT_STREAM_WRITER_TAB_EN
    logic [X_W:0]   tab_raw_c;
    logic [X_W-1:0] tab_x_c;
    assign tab_raw_c = {1'b0, cursor_x_q | X_W'(7)} + (X_W+1)'(1);
    assign tab_x_c   = (tab_raw_c > (X_W+1)'(TEXT_COLS - 1)) ? X_LAST : tab_raw_c[X_W-1:0];
`endif

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        in_ready_d   = in_ready_q;
        busy_d       = busy_q;
        cursor_x_d   = cursor_x_q;
        cursor_y_d   = cursor_y_q;
        xtextwrite_d = xtextwrite_q;
        ytextwrite_d = ytextwrite_q;
        value_d      = value_q;
        attr_d       = attr_load ? attr_in : attr_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    case (in_data)
                        CH_CR: cursor_x_d = '0;
                        CH_LF: cursor_y_d = lf_y_c;
                        CH_BS: if (cursor_x_q != '0) cursor_x_d = cursor_x_q - X_W'(1);
`ifdef TEXT_STREAM_WRITER_TAB_EN
                        CH_HT: cursor_x_d = tab_x_c;
`endif
                        CH_FF: begin
                            state_d      = S_CLR_SETUP;
                            xtextwrite_d = '0;
                            ytextwrite_d = '0;
                            value_d      = {attr_q, CH_SPACE};
                            in_ready_d   = 1'b0;
                            busy_d       = 1'b1;
                        end
                        default: begin
                            state_d      = S_SETUP;
                            xtextwrite_d = cursor_x_q;
                            ytextwrite_d = cursor_y_q;
                            value_d      = {attr_q, in_data};
                            in_ready_d   = 1'b0;
                            busy_d       = 1'b1;
                        end
                    endcase
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
                write_d = 1'b1;
            end
            S_STROBE: begin
                state_d    = S_IDLE;
                write_d    = 1'b0;
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
                cursor_x_d = adv_x_c;
                cursor_y_d = adv_y_c;
            end
            S_CLR_SETUP: begin
                state_d = S_CLR_STROBE;
                write_d = 1'b1;
            end
            S_CLR_STROBE: begin
                write_d = 1'b0;
                if (clr_last_c) begin
                    state_d    = S_IDLE;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b0;
                    cursor_x_d = '0;
                    cursor_y_d = '0;
                end else begin
                    // Next cell picks up whatever attribute is current now
                    state_d      = S_CLR_SETUP;
                    xtextwrite_d = clr_x_c;
                    ytextwrite_d = clr_y_c;
                    value_d      = {attr_q, CH_SPACE};
                end
            end
            default: begin
                state_d    = S_IDLE;
                write_d    = 1'b0;
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            cursor_x_q   <= '0;
            cursor_y_q   <= '0;
            xtextwrite_q <= '0;
            ytextwrite_q <= '0;
            value_q      <= '0;
            attr_q       <= '0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            cursor_x_q   <= cursor_x_d;
            cursor_y_q   <= cursor_y_d;
            xtextwrite_q <= xtextwrite_d;
            ytextwrite_q <= ytextwrite_d;
            value_q      <= value_d;
            attr_q       <= attr_d;
        end
    end

    assign write      = write_q;
    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign cursor_x   = cursor_x_q;
    assign cursor_y   = cursor_y_q;
    assign xtextwrite = xtextwrite_q;
    assign ytextwrite = ytextwrite_q;
    assign value      = value_q;

endmodule

// File: tb/tb_text_stream_writer.sv
// Self-checking bench for text_stream_writer: a byte-level model pushes expected cell writes,
// a negedge monitor pops them on each write rising edge.
module tb_text_stream_writer;

    localparam int COLS = 100;
    localparam int ROWS = 37;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        attr_load;
    logic [23:0] attr_in;
    logic        busy;
    logic [6:0]  cursor_x;
    logic [5:0]  cursor_y;
    logic        write;
    logic [6:0]  xtextwrite;
    logic [5:0]  ytextwrite;
    logic [31:0] value;

    text_stream_writer dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .attr_load(attr_load), .attr_in(attr_in), .busy(busy), .cursor_x(cursor_x),
        .cursor_y(cursor_y), .write(write), .xtextwrite(xtextwrite), .ytextwrite(ytextwrite),
        .value(value)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          pulses = 0;
    logic        write_prev = 1'b0;
    logic [44:0] exp_q[$];
    int          mx = 0;
    int          my = 0;
    logic [23:0] mattr = '0;

    // Scoreboard monitor: every write rising edge must match the oldest expected cell
    always @(negedge clk) begin
        logic [44:0] e;
        if (write && !write_prev) begin
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got x=%0d y=%0d v=%h, none expected",
                         xtextwrite, ytextwrite, value);
            end else begin
                e = exp_q.pop_front();
                if ({xtextwrite, ytextwrite, value} !== e) begin
                    errors++;
                    $display("FAIL write_cell: got x=%0d y=%0d v=%h, expected x=%0d y=%0d v=%h",
                             xtextwrite, ytextwrite, value, e[44:38], e[37:32], e[31:0]);
                end
            end
        end
        if (write && write_prev) begin
            checks++;
            errors++;
            $display("FAIL write_width: write high for more than one cycle, expected exactly 1");
        end
        write_prev = write;
    end

    task automatic push_exp(input int x, input int y, input logic [31:0] v);
        exp_q.push_back({7'(x), 6'(y), v});
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'h0D) mx = 0;
        else if (b == 8'h0A) my = (my == ROWS - 1) ? 0 : my + 1;
        else if (b == 8'h08) begin
            if (mx > 0) mx--;
        end else if (b == 8'h0C) begin
            for (int y = 0; y < ROWS; y++)
                for (int x = 0; x < COLS; x++) push_exp(x, y, {mattr, 8'h20});
            mx = 0;
            my = 0;
        end
`ifdef TEXT_STREAM_WRITER_TAB_EN
        else if (b == 8'h09) begin
            mx = (mx / 8 + 1) * 8;
            if (mx > COLS - 1) mx = COLS - 1;
        end
`endif
        else begin
            push_exp(mx, my, {mattr, b});
            mx++;
            if (mx == COLS) begin
                mx = 0;
                my = (my == ROWS - 1) ? 0 : my + 1;
            end
        end
    endtask

    // Handshake one byte; returns at the negedge right after the accepting edge
    task automatic send(input logic [7:0] b);
        logic rdy;
        int   n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        forever begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) break;
            n++;
            if (n > 20000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: byte %h not accepted, in_ready=%b expected 1", b, in_ready);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        model_byte(b);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(in_ready && !busy)) begin
            @(negedge clk);
            n++;
            if (n > 10000) begin
                checks++;
                errors++;
                $display("FAIL idle_timeout: busy=%b in_ready=%b, expected 0/1", busy, in_ready);
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; attr_load = 1'b0; attr_in = '0;
        #1;
        checks++;
        if ({write, in_ready, busy, cursor_x, cursor_y, xtextwrite, ytextwrite, value} !== {3'b010, 58'd0}) begin
            errors++;
            $display("FAIL reset_state: w=%b rdy=%b busy=%b cx=%0d cy=%0d xw=%0d yw=%0d v=%h, expected 0/1/0 and zeros",
                     write, in_ready, busy, cursor_x, cursor_y, xtextwrite, ytextwrite, value);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || write !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: rdy=%b busy=%b w=%b, expected 1/0/0", in_ready, busy, write);
        end
    endtask

    task automatic test_printable();
        int p0;
        @(negedge clk);
        attr_in = 24'h00F0F0; attr_load = 1'b1;
        @(negedge clk);
        attr_load = 1'b0; mattr = 24'h00F0F0;
        p0 = pulses;
        send(8'h41);
        checks++;
        if (write !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL setup_ctrl: w=%b busy=%b rdy=%b, expected 0/1/0", write, busy, in_ready);
        end
        checks++;
        if (xtextwrite !== 7'd0 || ytextwrite !== 6'd0 || value !== 32'h00F0F041) begin
            errors++;
            $display("FAIL setup_addr: x=%0d y=%0d v=%h, expected 0 0 00f0f041", xtextwrite, ytextwrite, value);
        end
        @(negedge clk);
        checks++;
        if (write !== 1'b1) begin
            errors++;
            $display("FAIL strobe: write=%b expected 1", write);
        end
        @(negedge clk);
        checks++;
        if (write !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || cursor_x !== 7'd1 || cursor_y !== 6'd0
            || xtextwrite !== 7'd0 || value !== 32'h00F0F041) begin
            errors++;
            $display("FAIL char_done: w=%b rdy=%b busy=%b cx=%0d cy=%0d xw=%0d v=%h, expected 0/1/0 (1,0) hold 0 00f0f041",
                     write, in_ready, busy, cursor_x, cursor_y, xtextwrite, value);
        end
        checks++;
        if (pulses - p0 !== 1) begin
            errors++;
            $display("FAIL char_pulses: got %0d expected 1", pulses - p0);
        end
    endtask

    task automatic test_wrap();
        send(8'h0D);
        repeat (36) send(8'h0A);
        for (int i = 0; i < 99; i++) send(8'(8'h41 + i % 26));
        wait_idle();
        checks++;
        if (cursor_x !== 7'd99 || cursor_y !== 6'd36) begin
            errors++;
            $display("FAIL corner_cursor: got (%0d,%0d) expected (99,36)", cursor_x, cursor_y);
        end
        send(8'h42);
        wait_idle();
        checks++;
        if (cursor_x !== 7'd0 || cursor_y !== 6'd0) begin
            errors++;
            $display("FAIL wrap_cursor: got (%0d,%0d) expected (0,0)", cursor_x, cursor_y);
        end
    endtask

    task automatic test_controls();
        logic [7:0] codes [3];
        int         exp_y [3];
        int         p0;
        codes = '{8'h0D, 8'h0A, 8'h08};
        exp_y = '{5, 6, 6};
        repeat (5) send(8'h0A);
        p0 = pulses;
        for (int i = 0; i < 3; i++) begin
            send(codes[i]);
            checks++;
            if (cursor_x !== 7'd0 || cursor_y !== 6'(exp_y[i]) || in_ready !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL ctrl_%h: got (%0d,%0d) rdy=%b busy=%b, expected (0,%0d) rdy=1 busy=0",
                         codes[i], cursor_x, cursor_y, in_ready, busy, exp_y[i]);
            end
        end
        checks++;
        if (pulses !== p0) begin
            errors++;
            $display("FAIL ctrl_pulses: got %0d expected 0", pulses - p0);
        end
        repeat (3) send(8'h61);
        send(8'h08);
        checks++;
        if (cursor_x !== 7'(mx) || cursor_y !== 6'(my) || mx != 2) begin
            errors++;
            $display("FAIL bs_step: got (%0d,%0d) expected (2,6)", cursor_x, cursor_y);
        end
    endtask

    task automatic test_clear();
        int p0, busy_cnt, n;
        wait_idle();
        p0 = pulses;
        send(8'h0C);
        busy_cnt = 0;
        n = 0;
        in_data  = 8'h43;
        in_valid = 1'b1;
        while (!in_ready && n < 8000) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy_cnt !== 7400) begin
            errors++;
            $display("FAIL clear_busy: got %0d cycles expected 7400", busy_cnt);
        end
        checks++;
        if (pulses - p0 !== 3700 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL clear_pulses: got %0d pulses, %0d pending, expected 3700 and 0",
                     pulses - p0, exp_q.size());
        end
        checks++;
        if (cursor_x !== 7'd0 || cursor_y !== 6'd0) begin
            errors++;
            $display("FAIL clear_cursor: got (%0d,%0d) expected (0,0)", cursor_x, cursor_y);
        end
        send(8'h43);
        wait_idle();
        checks++;
        if (cursor_x !== 7'd1 || cursor_y !== 6'd0) begin
            errors++;
            $display("FAIL held_byte: cursor (%0d,%0d) expected (1,0)", cursor_x, cursor_y);
        end
    endtask

    task automatic test_reset_mid_clear();
        int p0, p1, n;
        wait_idle();
        send(8'h0C);
        p0 = pulses;
        n = 0;
        while (!(write && pulses - p0 >= 10) && n < 200) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b1;
        #1;
        checks++;
        if (write !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || cursor_x !== 7'd0 || cursor_y !== 6'd0) begin
            errors++;
            $display("FAIL mid_reset: w=%b busy=%b rdy=%b cursor (%0d,%0d), expected 0/0/1 (0,0)",
                     write, busy, in_ready, cursor_x, cursor_y);
        end
        exp_q.delete();
        mx = 0; my = 0; mattr = '0;
        @(negedge clk);
        reset = 1'b0;
        p1 = pulses;
        repeat (20) @(negedge clk);
        checks++;
        if (pulses !== p1) begin
            errors++;
            $display("FAIL after_reset_pulses: got %0d expected 0", pulses - p1);
        end
        send(8'h41);
        wait_idle();
        checks++;
        if (cursor_x !== 7'd1 || cursor_y !== 6'd0) begin
            errors++;
            $display("FAIL post_abort_char: cursor (%0d,%0d) expected (1,0)", cursor_x, cursor_y);
        end
    endtask

    task automatic test_tab();
        int p0;
        send(8'h0D);
        send(8'h0A);
        send(8'h0A);
        repeat (3) send(8'h74);
        wait_idle();
        p0 = pulses;
        send(8'h09);
`ifdef TEXT_STREAM_WRITER_TAB_EN
        checks++;
        if (cursor_x !== 7'd8 || cursor_y !== 6'd2 || in_ready !== 1'b1 || pulses !== p0) begin
            errors++;
            $display("FAIL tab_step: got (%0d,%0d) rdy=%b pulses=%0d, expected (8,2) rdy=1 pulses=0",
                     cursor_x, cursor_y, in_ready, pulses - p0);
        end
        send(8'h0D);
        repeat (98) send(8'h2E);
        wait_idle();
        send(8'h09);
        checks++;
        if (cursor_x !== 7'd99 || cursor_y !== 6'd2) begin
            errors++;
            $display("FAIL tab_clamp: got (%0d,%0d) expected (99,2)", cursor_x, cursor_y);
        end
`else
        wait_idle();
        checks++;
        if (cursor_x !== 7'd4 || cursor_y !== 6'd2 || pulses - p0 !== 1) begin
            errors++;
            $display("FAIL ht_printable: got (%0d,%0d) pulses=%0d, expected (4,2) pulses=1",
                     cursor_x, cursor_y, pulses - p0);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_printable();
        test_wrap();
        test_controls();
        test_clear();
        test_reset_mid_clear();
        test_tab();
        wait_idle();
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL drain: %0d expected writes never seen, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
